// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA receive-side frame monitor.
// Holds default geometry, CRC-16-CCITT constants and the monitor state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    FRAME = 2'd1,
    CLOSE = 2'd2
  } mon_state_e;

  // One bit of CRC-16-CCITT, MSB-first, no reflection.
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/pixel_crc16.sv
// Combinational next-state of CRC-16-CCITT after absorbing one 24-bit {r,g,b} pixel.
// Bits are consumed MSB first, so red bit 7 enters the register first.
module pixel_crc16
  import vga_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] pixel,
  output logic [15:0] crc_out
);

  always_comb begin
    // NOTE: every variable written in always_comb gets a value on entry, so no latch can form.
    crc_out = crc_in;
    for (int i = 23; i >= 0; i--) begin
      crc_out = crc16_bit(crc_out, pixel[i]);
    end
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: recovers x/y from BLANK_n/VS, checks line and frame geometry,
// accumulates a per-frame pixel CRC and captures one probe pixel.
module vga_frame_monitor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = 11
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             iHS,
  input  logic             iVS,
  input  logic             iBLANK_n,
  input  logic [7:0]       r_data,
  input  logic [7:0]       g_data,
  input  logic [7:0]       b_data,
  input  logic [CNT_W-1:0] probe_x,
  input  logic [CNT_W-1:0] probe_y,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [15:0]      frame_crc,
  output logic [CNT_W-1:0] line_count,
  output logic             line_err,
  output logic [15:0]      frame_count,
  output logic [23:0]      probe_rgb,
  output logic             probe_valid
);

  localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);

  // ---------------- input registers and edge detect ----------------
  logic             hs_q, vs_q, blank_q;
  logic             vs_d, blank_d;
  logic [23:0]      rgb_q;
  logic [CNT_W-1:0] probe_x_q, probe_y_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      blank_q   <= 1'b0;
      vs_d      <= 1'b0;
      blank_d   <= 1'b0;
      rgb_q     <= '0;
      probe_x_q <= '0;
      probe_y_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      hs_q      <= iHS;
      vs_q      <= iVS;
      blank_q   <= iBLANK_n;
      vs_d      <= vs_q;
      blank_d   <= blank_q;
      rgb_q     <= {r_data, g_data, b_data};
      probe_x_q <= probe_x;
      probe_y_q <= probe_y;
    end
  end

  // A VS fall counts only while HS is low, matching the controller's address reset.
  logic vs_fall, blank_fall;
  assign vs_fall    = vs_d & ~vs_q & ~hs_q;
  assign blank_fall = blank_d & ~blank_q;

  // ---------------- FSM ----------------
  mon_state_e state_q, state_n;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= SEEK;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      SEEK:    if (vs_fall) state_n = FRAME;
      FRAME:   if (vs_fall) state_n = CLOSE;
      CLOSE:   state_n = FRAME;
      default: state_n = SEEK;
    endcase
  end

  logic in_frame, close_en;
  always_comb begin
    in_frame = 1'b0;
    close_en = 1'b0;
    unique case (state_q)
      FRAME:   in_frame = 1'b1;
      CLOSE:   close_en = 1'b1;
      default: ;
    endcase
  end

  // ---------------- per-frame accumulators ----------------
  logic             pix_en, trunc_line, line_end, line_bad;
  logic [CNT_W-1:0] x_q, y_q;
  logic [15:0]      crc_acc, crc_next;
  logic             line_err_acc, sat_acc;
  logic [23:0]      cap_rgb;
  logic             cap_flag;

  assign pix_en     = in_frame & blank_q;
  // A line still open when VS falls is closed here and always counted as bad.
  assign trunc_line = in_frame & vs_fall & blank_q;
  assign line_end   = (in_frame & blank_fall) | trunc_line;
  assign line_bad   = trunc_line | (in_frame & blank_fall & (x_q != H_EXP));

  pixel_crc16 u_crc (
    .crc_in  (crc_acc),
    .pixel   (rgb_q),
    .crc_out (crc_next)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_q          <= '0;
      y_q          <= '0;
      crc_acc      <= CRC16_INIT;
      line_err_acc <= 1'b0;
      sat_acc      <= 1'b0;
      cap_rgb      <= '0;
      cap_flag     <= 1'b0;
    end else if (!in_frame) begin
      // SEEK discards everything; CLOSE restarts the accumulators for the next frame.
      x_q          <= '0;
      y_q          <= '0;
      crc_acc      <= CRC16_INIT;
      line_err_acc <= 1'b0;
      sat_acc      <= 1'b0;
      cap_rgb      <= '0;
      cap_flag     <= 1'b0;
    end else begin
      if (pix_en) begin
        crc_acc <= crc_next;
        if (x_q == probe_x_q && y_q == probe_y_q) begin
          cap_rgb  <= rgb_q;
          cap_flag <= 1'b1;
        end
      end

      if (line_end) begin
        x_q <= '0;
        if (line_bad) line_err_acc <= 1'b1;
        if (&y_q) sat_acc <= 1'b1;
        else      y_q     <= y_q + 1'b1;
      end else if (pix_en) begin
        if (&x_q) sat_acc <= 1'b1;
        else      x_q     <= x_q + 1'b1;
      end
    end
  end

  // ---------------- result registers ----------------
  logic [15:0] frame_cnt_q;
  assign frame_count = frame_cnt_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_crc   <= '0;
      line_count  <= '0;
      line_err    <= 1'b0;
      frame_cnt_q <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      frame_done <= close_en;
      if (close_en) begin
        frame_ok    <= (y_q == V_EXP) && !line_err_acc && !sat_acc;
        frame_crc   <= crc_acc;
        line_count  <= y_q;
        line_err    <= line_err_acc;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        probe_rgb   <= cap_rgb;
        probe_valid <= cap_flag;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a reduced 16x24 geometry; the expected CRC comes
// from an independent byte-wise CRC-16-CCITT model updated as pixels are driven.
module tb_vga_frame_monitor;

  localparam int H = 16;
  localparam int V = 24;
  localparam int CW = 11;

  logic          iVGA_CLK = 1'b0;
  logic          iRST_n   = 1'b0;
  logic          iHS = 1'b1, iVS = 1'b1, iBLANK_n = 1'b0;
  logic [7:0]    r_data = '0, g_data = '0, b_data = '0;
  logic [CW-1:0] probe_x = '0, probe_y = '0;
  logic          frame_done, frame_ok, line_err, probe_valid;
  logic [15:0]   frame_crc, frame_count;
  logic [CW-1:0] line_count;
  logic [23:0]   probe_rgb;

  vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
    .iVGA_CLK    (iVGA_CLK),
    .iRST_n      (iRST_n),
    .iHS         (iHS),
    .iVS         (iVS),
    .iBLANK_n    (iBLANK_n),
    .r_data      (r_data),
    .g_data      (g_data),
    .b_data      (b_data),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_crc   (frame_crc),
    .line_count  (line_count),
    .line_err    (line_err),
    .frame_count (frame_count),
    .probe_rgb   (probe_rgb),
    .probe_valid (probe_valid)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [15:0] model_crc;
  logic [15:0] crc_b;
  int done_before;

  always @(negedge iVGA_CLK) if (frame_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // mode 0: patterned frame with 24'hA5C33C at (10,20); mode 1: all black
  function automatic logic [23:0] pix(input int x, input int y, input int mode);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    if (mode == 1) return 24'h000000;
    if (x == 10 && y == 20) return 24'hA5C33C;
    return {(xb * 8'd3) ^ yb, yb + 8'h40, xb ^ 8'h5A};
  endfunction

  task automatic cyc(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    iHS = hs; iVS = vs; iBLANK_n = bl;
    {r_data, g_data, b_data} = rgb;
    @(negedge iVGA_CLK);
  endtask

  task automatic line(input int y, input int len, input int mode);
    logic [23:0] p;
    for (int x = 0; x < len; x++) begin
      p = pix(x, y, mode);
      model_crc = crc_byte(crc_byte(crc_byte(model_crc, p[23:16]), p[15:8]), p[7:0]);
      cyc(1'b1, 1'b1, 1'b1, p);
    end
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic frame(input int nlines, input int short_y, input int mode);
    model_crc = 16'hFFFF;
    for (int y = 0; y < nlines; y++) line(y, (y == short_y) ? H - 1 : H, mode);
  endtask

  task automatic vs_pulse();
    done_before = done_cnt;
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  // VS falls while BLANK_n is still high: the open line is truncated.
  task automatic vs_pulse_trunc();
    done_before = done_cnt;
    cyc(1'b0, 1'b0, 1'b1, 24'h123456);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  initial begin
    repeat (3) @(negedge iVGA_CLK);
    iRST_n = 1'b1;

    // open a frame, run part of it, then reset mid-frame
    vs_pulse();
    frame(5, -1, 0);
    iRST_n = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    check("rst_done", 32'(done_cnt), 32'd0);
    check("rst_ok", 32'(frame_ok), 32'd0);
    check("rst_crc", 32'(frame_crc), 32'd0);
    check("rst_lines", 32'(line_count), 32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);
    check("rst_pvalid", 32'(probe_valid), 32'd0);
    iRST_n = 1'b1;
    cyc(1'b1, 1'b1, 0, 24'h0);

    // first VS fall after reset only opens a frame
    probe_x = 11'd10;
    probe_y = 11'd20;
    vs_pulse();
    check("seek_silent", 32'(done_cnt), 32'd0);
    frame(V, -1, 0);
    vs_pulse();
    check("A_done", 32'(done_cnt), 32'd1);
    check("A_ok", 32'(frame_ok), 32'd1);
    check("A_lines", 32'(line_count), 32'(V));
    check("A_lerr", 32'(line_err), 32'd0);
    check("A_crc", 32'(frame_crc), 32'(model_crc));
    check("A_fcount", 32'(frame_count), 32'd1);
    check("A_pvalid", 32'(probe_valid), 32'd1);
    check("A_prgb", 32'(probe_rgb), 32'hA5C33C);

    // black frame, probe out of range
    probe_x = 11'd700;
    probe_y = 11'd0;
    frame(V, -1, 1);
    vs_pulse();
    crc_b = model_crc;
    check("B_crc", 32'(frame_crc), 32'(crc_b));
    check("B_pvalid", 32'(probe_valid), 32'd0);
    check("B_fcount", 32'(frame_count), 32'd2);

    frame(V, -1, 1);
    vs_pulse();
    check("C_crc_repeat", 32'(frame_crc), 32'(crc_b));
    check("C_done", 32'(done_cnt - done_before), 32'd1);

    // line 10 one pixel short
    frame(V, 10, 0);
    vs_pulse();
    check("D_ok", 32'(frame_ok), 32'd0);
    check("D_lerr", 32'(line_err), 32'd1);
    check("D_lines", 32'(line_count), 32'(V));

    frame(V, -1, 0);
    vs_pulse();
    check("E_lerr", 32'(line_err), 32'd0);
    check("E_ok", 32'(frame_ok), 32'd1);

    // one line missing
    frame(V - 1, -1, 0);
    vs_pulse();
    check("F_lines", 32'(line_count), 32'(V - 1));
    check("F_ok", 32'(frame_ok), 32'd0);
    check("F_lerr", 32'(line_err), 32'd0);

    // full frame plus a partial line cut off by VS
    frame(V, -1, 0);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 24'h010203);
    vs_pulse_trunc();
    check("G_lines", 32'(line_count), 32'(V + 1));
    check("G_lerr", 32'(line_err), 32'd1);
    check("G_ok", 32'(frame_ok), 32'd0);

    // frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    release dut.frame_cnt_q;
    frame(V, -1, 0);
    vs_pulse();
    check("H_fcount_wrap", 32'(frame_count), 32'd0);
    check("H_done_once", 32'(done_cnt - done_before), 32'd1);
    check("H_ok", 32'(frame_ok), 32'd1);
    check("H_crc", 32'(frame_crc), 32'(model_crc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
